// File: rtl/sprite_line_fetcher.sv
// Fetches one 64-pixel, 4-bpp sprite row from the sprite ROM into a local line buffer,
// then streams it one pixel per valid/ready transfer, MSB nibble of each word first.
module sprite_line_fetcher #(
    parameter int unsigned ROM_LATENCY   = 2,
    parameter int unsigned WORDS_PER_ROW = 16
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  sprite_sel_i,
    input  logic [5:0]  row_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  rom_sprite_sel_o,
    output logic [9:0]  rom_word_addr_o,
    input  logic [15:0] rom_data_i,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic [3:0]  pix_o,
    output logic [5:0]  pix_x_o,
    output logic        pix_last_o
);

    localparam int unsigned DrainW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StStream} state_t;

    state_t                  state_q;
    logic [3:0]              fetch_cnt_q;
    logic [3:0]              cap_cnt_q;
    logic [ROM_LATENCY-1:0]  cap_pipe_q;
    logic [DrainW-1:0]       drain_cnt_q;
    logic [5:0]              x_q;
    logic [2:0]              sel_q;
    logic [9:0]              addr_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic [15:0]             buf_q [WORDS_PER_ROW];

    logic                    xfer;
    logic                    capture;
    logic [ROM_LATENCY:0]    pipe_next;
    logic [15:0]             word;

    assign xfer      = valid_q & pix_ready_i;
    // A request issued in FETCH returns ROM_LATENCY cycles later; the pipe tags those cycles.
    assign capture   = cap_pipe_q[ROM_LATENCY-1];
    assign pipe_next = {cap_pipe_q, (state_q == StFetch)};

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= StIdle;
            fetch_cnt_q <= '0;
            cap_cnt_q   <= '0;
            cap_pipe_q  <= '0;
            drain_cnt_q <= '0;
            x_q         <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            cap_pipe_q <= pipe_next[ROM_LATENCY-1:0];
            if (capture) begin
                cap_cnt_q <= cap_cnt_q + 4'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        sel_q       <= sprite_sel_i;
                        addr_q      <= {row_i, 4'd0};
                        fetch_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StFetch;
                    end
                end
                StFetch: begin
                    if (fetch_cnt_q == 4'(WORDS_PER_ROW - 1)) begin
                        drain_cnt_q <= '0;
                        state_q     <= StDrain;
                    end else begin
                        fetch_cnt_q <= fetch_cnt_q + 4'd1;
                        addr_q[3:0] <= fetch_cnt_q + 4'd1;
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == DrainW'(ROM_LATENCY - 1)) begin
                        x_q     <= '0;
                        valid_q <= 1'b1;
                        state_q <= StStream;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                StStream: begin
                    if (xfer) begin
                        x_q <= x_q + 6'd1;
                        if (x_q == 6'd63) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Line buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst_i && capture) begin
            buf_q[cap_cnt_q] <= rom_data_i;
        end
    end

    always_comb begin
        word  = buf_q[x_q[5:2]];
        pix_o = 4'd0;
        if (valid_q) begin
            unique case (x_q[1:0])
                2'd0: pix_o = word[15:12];
                2'd1: pix_o = word[11:8];
                2'd2: pix_o = word[7:4];
                2'd3: pix_o = word[3:0];
                default: pix_o = 4'd0;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign rom_sprite_sel_o = sel_q;
    assign rom_word_addr_o  = addr_q;
    assign pix_valid_o      = valid_q;
    assign pix_x_o          = x_q;
    assign pix_last_o       = valid_q && (x_q == 6'd63);

endmodule
